latch_strobe_tx: RTL and testbench
==================================

# latch_strobe_tx

Drive side of a level-sensitive transparent-latch capture interface. Accepts one data word per valid/ready handshake and presents it on `lat_d`. Generates the timed `lat_en` window a downstream D latch needs: data set up before the enable opens, enable held open, data held after the enable closes. Sits between a streaming producer and any latch-based holding register in the sequential-circuit library.

## Interface
Parameters:
- `DATA_W`, 8: width of data word.
- `SETUP_CYC`, 2: cycles `lat_d` is stable before `lat_en` rises; legal range ≥1.
- `PULSE_CYC`, 3: cycles `lat_en` is high; legal range ≥1.
- `HOLD_CYC`, 2: cycles `lat_d` is held after `lat_en` falls; legal range ≥1.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer has a word.
- `in_ready` output 1: block can accept a word.
- `in_data` input DATA_W: word to transmit.
- `lat_d` output DATA_W: data to latch D input, registered.
- `lat_en` output 1: latch enable (transparent when high), registered.
- `busy` output 1: transfer in progress; equals `!in_ready`.
- `done` output 1: one-cycle pulse when a transfer completes.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- A down-counter is loaded on each state entry.
- IDLE: `in_ready`=1, `lat_en`=0.
  - `in_valid && in_ready` at an edge registers `lat_d <= in_data` and moves to SETUP.
- SETUP: `lat_en`=0 for SETUP_CYC cycles, then PULSE.
- PULSE: `lat_en`=1 for PULSE_CYC cycles, then HOLD.
- HOLD: `lat_en`=0 for HOLD_CYC cycles, then IDLE with `done`=1 for that first IDLE cycle.
- `lat_d` changes only on an accepted handshake.
  - Stable through SETUP, PULSE and HOLD.
  - Retains its last value in IDLE.
- `in_valid`/`in_data` activity while busy is ignored; no buffering.
- Illegal parameter (any *_CYC < 1): elaboration-time error via generate-time check.

## Timing
- Reset values: state IDLE, `lat_d`=0, `lat_en`=0, `done`=0, `in_ready`=1, `busy`=0.
- Reset mid-transfer: `lat_en` and `lat_d` clear immediately (asynchronous) and the transfer is abandoned. No `done` is produced.
- Accept at edge E0 produces this sequence:
  - Cycles 1..SETUP_CYC: SETUP.
  - Cycles SETUP_CYC+1..SETUP_CYC+PULSE_CYC: `lat_en`=1.
  - Next HOLD_CYC cycles: HOLD.
  - Cycle SETUP_CYC+PULSE_CYC+HOLD_CYC+1: IDLE, with `done`=1 and `in_ready`=1.
- Back-to-back: a word offered during the `done` cycle is accepted at the next edge. Minimum period is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
- With the default parameters, the period is 8 cycles and `lat_en` is high in cycles 3–5.
- `lat_en` never rises in the cycle `lat_d` changes, and never falls in the cycle `lat_d` changes.

## Configuration
- Macro `LATCH_STROBE_READBACK_EN`.
- Defined: adds input `lat_q` (DATA_W) and output `err` (1).
  - On the edge ending the last HOLD cycle, `lat_q` is compared to `lat_d`.
  - A mismatch sets `err`, which is sticky; only `rst_n` clears it. Reset value is 0.
  - Timing of all other outputs is unchanged.
- Undefined: neither port exists and there is no compare logic.

## Test plan
- Reset check: `rst_n`=0 then release.
  - Required: `lat_d`=0, `lat_en`=0, `done`=0, `in_ready`=1 in the first cycle after release.
- Single transfer, defaults: send 0xA5 at E0.
  - Required: `lat_d`=0xA5 from cycle 1.
  - Required: `lat_en`=1 exactly in cycles 3, 4 and 5.
  - Required: `done`=1 only in cycle 8, with `in_ready` low in cycles 1–7.
- Back-to-back: `in_valid` held high with words 0x11 then 0x22.
  - Required: the second accept happens at the edge ending the `done` cycle, giving an 8-cycle period.
  - Required: `in_data` changes while busy do not alter `lat_d`.
- Reset mid-PULSE: `rst_n` asserted in cycle 4.
  - Required: `lat_en`=0 and `lat_d`=0 immediately, with no `done` afterwards.
  - Required: a new word is accepted normally after release.
- Parameter sweep: SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=1.
  - Required: `lat_en` high only in cycle 2, `done` in cycle 4.
- Readback (macro defined): a bench model latch drives `lat_q`.
  - Required: `err` stays 0 when the latch is correct.
  - Required: forcing `lat_q` bit 0 wrong during HOLD sets `err`=1, and it stays 1 until reset.

Source files
------------

// File: rtl/latch_strobe_tx.sv
// Drive side of a transparent-latch capture interface: presents a word on lat_d and
// generates the setup / enable / hold window. Optional readback check: LATCH_STROBE_READBACK_EN.
module latch_strobe_tx #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] lat_d,
    output logic              lat_en,
    output logic              busy,
`ifdef LATCH_STROBE_READBACK_EN
    input  logic [DATA_W-1:0] lat_q,
    output logic              err,
`endif
    output logic              done
);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("latch_strobe_tx: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  lat_d_q, lat_d_d;
    logic               lat_en_q, lat_en_d;
    logic               done_q, done_d;
    logic               last_cyc;

    assign last_cyc = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            done_q   <= done_d;
        end
    end

    // Counter is loaded with (length-1) on entry, so each state lasts exactly its length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d_d = lat_d_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    lat_d_d = in_data;
                end
            end
            SETUP: begin
                if (last_cyc) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (last_cyc) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (last_cyc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        lat_en_d = (state_d == PULSE);
    end

`ifdef LATCH_STROBE_READBACK_EN
    logic err_q, err_d;

    // Latch is closed and settled by the final HOLD cycle; sample it on the edge leaving HOLD.
    always_comb begin
        err_d = err_q;
        if (state_q == HOLD && last_cyc && lat_q != lat_d_q) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign in_ready = (state_q == IDLE);
    assign busy     = !in_ready;
    assign lat_d    = lat_d_q;
    assign lat_en   = lat_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Directed bench for latch_strobe_tx: defaults instance plus a 1/1/1 instance.
// Readback checks are compiled in with LATCH_STROBE_READBACK_EN.
module tb_latch_strobe_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, lat_en, busy, done;
    logic [7:0] in_data, lat_d;
    logic       v1, r1, en1, b1, dn1;
    logic [7:0] d1, ld1;
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef LATCH_STROBE_READBACK_EN
    logic [7:0] lat_q_m, lat_q, lat_q1;
    logic       err, err1, flip;
    always_latch if (lat_en) lat_q_m <= lat_d;
    assign lat_q  = lat_q_m ^ {7'd0, flip};
    assign lat_q1 = ld1;
`endif

    always #5 clk = ~clk;

    latch_strobe_tx u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .lat_d(lat_d), .lat_en(lat_en), .busy(busy),
`ifdef LATCH_STROBE_READBACK_EN
        .lat_q(lat_q), .err(err),
`endif
        .done(done)
    );

    latch_strobe_tx #(.DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_min (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_data(d1), .lat_d(ld1), .lat_en(en1), .busy(b1),
`ifdef LATCH_STROBE_READBACK_EN
        .lat_q(lat_q1), .err(err1),
`endif
        .done(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Offer word w at a negedge (accepted at the next posedge, E0), then check
    // cycles 1..8 of the default 2/3/2 sequence. Optionally change in_data while busy.
    task automatic run_default(input logic [7:0] w, input logic [7:0] noise, input bit keep_valid);
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                in_valid = keep_valid;
                in_data  = noise;
            end
            chk($sformatf("lat_d c%0d", c), lat_d, w);
            chk($sformatf("lat_en c%0d", c), lat_en, (c >= 3 && c <= 5));
            chk($sformatf("done c%0d", c), done, (c == 8));
            chk($sformatf("in_ready c%0d", c), in_ready, (c == 8));
            chk($sformatf("busy c%0d", c), busy, (c != 8));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; v1 = 1'b0; d1 = 8'h00;
`ifdef LATCH_STROBE_READBACK_EN
        flip = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst lat_d", lat_d, 8'h00);
        chk("rst lat_en", lat_en, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst busy", busy, 1'b0);

        // single transfer
        run_default(8'hA5, 8'hA5, 1'b0);
        @(negedge clk);
        chk("single done cleared", done, 1'b0);
        chk("single lat_d retained", lat_d, 8'hA5);
`ifdef LATCH_STROBE_READBACK_EN
        chk("rb err clean", err, 1'b0);
`endif

        // back-to-back: 0x11 then 0x22 offered continuously, junk while busy
        run_default(8'h11, 8'h22, 1'b1);
        run_default(8'h22, 8'h33, 1'b0);
        @(negedge clk);
        chk("b2b idle after", in_ready, 1'b1);

`ifdef LATCH_STROBE_READBACK_EN
        // corrupt latch output bit 0 during HOLD
        in_valid = 1'b1; in_data = 8'h6C;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
            if (c == 6) flip = 1'b1;
            if (c == 7) chk("rb err before", err, 1'b0);
            if (c == 8) begin
                flip = 1'b0;
                chk("rb err set", err, 1'b1);
            end
        end
        run_default(8'h0F, 8'h0F, 1'b0);
        chk("rb err sticky", err, 1'b1);
`endif

        // reset during PULSE (cycle 4)
        in_valid = 1'b1; in_data = 8'h5A;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) in_valid = 1'b0;
        end
        chk("mid lat_en pre", lat_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid lat_en async", lat_en, 1'b0);
        chk("mid lat_d async", lat_d, 8'h00);
`ifdef LATCH_STROBE_READBACK_EN
        chk("rb err cleared", err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("mid no done c%0d", c), done, 1'b0);
        end
        chk("mid idle", in_ready, 1'b1);
        run_default(8'h3C, 8'hC3, 1'b0);

        // 1/1/1 instance
        @(negedge clk);
        v1 = 1'b1; d1 = 8'h77;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                v1 = 1'b0;
                d1 = 8'h88;
            end
            chk($sformatf("min lat_d c%0d", c), ld1, 8'h77);
            chk($sformatf("min lat_en c%0d", c), en1, (c == 2));
            chk($sformatf("min done c%0d", c), dn1, (c == 4));
            chk($sformatf("min ready c%0d", c), r1, (c >= 4));
        end
`ifdef LATCH_STROBE_READBACK_EN
        chk("min err", err1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
